// File: rtl/seg7_scan_ctrl_if.sv
// Host-side write port for the seg7 scan controller's digit registers.
interface seg7_scan_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic       wr_raw;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_raw, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_raw, wr_data);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit, 8-segment scan controller: round-robin digit slots, each a
// blank gap followed by a 16-step PWM ON phase. All pins are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BLANK | all digits/segments dark for BLANK_CYCLES (ghost suppression)
// S_ON    | digit idx_q driven for 16*STEP_CYCLES, lit while step < bri
module seg7_scan_ctrl #(
  parameter int BLANK_CYCLES   = 64,
  parameter int STEP_CYCLES    = 256,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              run,
  seg7_scan_ctrl_if.slave   wr,
  input  logic [3:0]        brightness,
  input  logic [3:0]        digit_mask,
  output logic [3:0]        indicator,
  output logic [7:0]        segment,
  output logic              frame_tick
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
  localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t          state_q;
  logic [1:0]      idx_q;
  logic [BW-1:0]   blank_cnt_q;
  logic [SW-1:0]   step_cnt_q;
  logic [3:0]      step_q;
  logic [7:0]      seg_lat_q;
  logic [3:0]      bri_lat_q;
  logic            msk_lat_q;
  logic [3:0]      indicator_q;
  logic [7:0]      segment_q;
  logic            frame_tick_q;
  logic [7:0]      digit_q [4];

  logic [7:0]      wr_pat_d;
  logic            lit_d;
  logic [3:0]      sel_d;
  logic [3:0]      indicator_d;
  logic [7:0]      segment_d;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign wr_pat_d = wr.wr_raw ? wr.wr_data : {wr.wr_data[4], hex7(wr.wr_data[3:0])};

  // Pin values for the current internal state; registered below.
  assign lit_d       = (state_q == S_ON) && (step_q < bri_lat_q) && msk_lat_q;
  assign sel_d       = 4'b0001 << idx_q;
  assign indicator_d = lit_d ? (DIG_ACTIVE_LOW ? ~sel_d : sel_d) : DIG_OFF;
  assign segment_d   = lit_d ? (SEG_ACTIVE_LOW ? ~seg_lat_q : seg_lat_q) : SEG_OFF;

  // Digit registers: always hold the raw active-high pattern; only reset clears them.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= 8'h00;
    end else if (wr.wr_en) begin
      digit_q[wr.wr_addr] <= wr_pat_d;
    end
  end

  // Slot sequencer with registered pins; run=0 parks it at digit 0 BLANK.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= S_BLANK;
      idx_q        <= 2'd0;
      blank_cnt_q  <= '0;
      step_cnt_q   <= '0;
      step_q       <= 4'd0;
      seg_lat_q    <= 8'h00;
      bri_lat_q    <= 4'd0;
      msk_lat_q    <= 1'b0;
      indicator_q  <= DIG_OFF;
      segment_q    <= SEG_OFF;
      frame_tick_q <= 1'b0;
    end else if (!run) begin
      state_q      <= S_BLANK;
      idx_q        <= 2'd0;
      blank_cnt_q  <= '0;
      step_cnt_q   <= '0;
      step_q       <= 4'd0;
      indicator_q  <= DIG_OFF;
      segment_q    <= SEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      indicator_q  <= indicator_d;
      segment_q    <= segment_d;
      frame_tick_q <= 1'b0;
      case (state_q)
        S_BLANK: begin
          if (blank_cnt_q == BLANK_LAST) begin
            // Latch everything the slot displays so mid-slot writes cannot tear it.
            blank_cnt_q <= '0;
            step_cnt_q  <= '0;
            step_q      <= 4'd0;
            seg_lat_q   <= digit_q[idx_q];
            bri_lat_q   <= brightness;
            msk_lat_q   <= digit_mask[idx_q];
            state_q     <= S_ON;
          end else begin
            blank_cnt_q <= blank_cnt_q + BW'(1);
          end
        end
        S_ON: begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_q <= '0;
            if (step_q == 4'd15) begin
              state_q      <= S_BLANK;
              idx_q        <= idx_q + 2'd1;
              frame_tick_q <= (idx_q == 2'd3);
            end else begin
              step_q <= step_q + 4'd1;
            end
          end else begin
            step_cnt_q <= step_cnt_q + SW'(1);
          end
        end
        default: state_q <= S_BLANK;
      endcase
    end
  end

  assign indicator  = indicator_q;
  assign segment    = segment_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with BLANK_CYCLES=2, STEP_CYCLES=1:
// 18-cycle slots, 72-cycle frames.
module tb_seg7_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] brightness;
  logic [3:0] digit_mask;
  logic [3:0] indicator;
  logic [7:0] segment;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl_if wif ();

  seg7_scan_ctrl #(
    .BLANK_CYCLES(2), .STEP_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .run(run), .wr(wif.slave),
    .brightness(brightness), .digit_mask(digit_mask),
    .indicator(indicator), .segment(segment), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {frame_tick, indicator, segment} at sample k (k=1 is the first
  // posedge with run=1 after a restart). Pins lag the internal state by one
  // clock, so sample k shows internal cycle j=k-1. Per slot: 2 blank cycles,
  // then 16 ON steps, lit while step < bri.
  function automatic logic [12:0] model(input int k, input logic [3:0] bri,
                                        input logic [3:0] msk, input logic [31:0] pats);
    int         j, slot, pos;
    logic       lit, ft;
    logic [3:0] ind;
    logic [7:0] seg, p;
    j    = k - 1;
    slot = (j / 18) % 4;
    pos  = j % 18;
    p    = pats[slot*8 +: 8];
    lit  = (pos >= 2) && ((pos - 2) < int'(bri)) && msk[slot];
    ind  = 4'hF;
    ind[slot] = ~lit;
    seg  = lit ? ~p : 8'hFF;
    ft   = (j % 72) == 71;
    return {ft, ind, seg};
  endfunction

  task automatic wr(input logic [1:0] a, input logic raw, input logic [7:0] d);
    @(negedge clk);
    wif.wr_en = 1'b1; wif.wr_addr = a; wif.wr_raw = raw; wif.wr_data = d;
    @(negedge clk);
    wif.wr_en = 1'b0;
  endtask

  // Park the scan for one clock, then re-enable; next posedge is sample k=1.
  task automatic restart();
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    run = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst = 1'b1; run = 1'b0; brightness = 4'd15; digit_mask = 4'hF;
    wif.wr_en = 1'b0; wif.wr_addr = 2'd0; wif.wr_raw = 1'b1; wif.wr_data = 8'h00;
    e = {1'b0, 4'hF, 8'hFF};
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL reset_state got %h exp %h", {frame_tick, indicator, segment}, e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_raw_scan();
    logic [12:0] e;
    wr(2'd0, 1'b1, 8'h01); wr(2'd1, 1'b1, 8'h02);
    wr(2'd2, 1'b1, 8'h04); wr(2'd3, 1'b1, 8'h08);
    brightness = 4'd15; digit_mask = 4'hF;
    restart();
    for (int k = 1; k <= 144; k++) begin
      @(posedge clk); @(negedge clk);
      e = model(k, 4'd15, 4'hF, 32'h08040201);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL raw_scan k=%0d got %h exp %h", k, {frame_tick, indicator, segment}, e);
      end
    end
  endtask

  task automatic test_hex_decode();
    logic [12:0] e;
    wr(2'd2, 1'b0, 8'h1A);   // A with dp -> 0xF7
    wr(2'd3, 1'b0, 8'h05);   // 5 no dp   -> 0x6D
    restart();
    for (int k = 1; k <= 72; k++) begin
      @(posedge clk); @(negedge clk);
      e = model(k, 4'd15, 4'hF, 32'h6DF70201);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL hex_decode k=%0d got %h exp %h", k, {frame_tick, indicator, segment}, e);
      end
    end
  endtask

  task automatic test_brightness();
    logic [12:0] e;
    logic [3:0]  levels [2];
    levels[0] = 4'd4; levels[1] = 4'd0;
    for (int b = 0; b < 2; b++) begin
      brightness = levels[b];
      restart();
      for (int k = 1; k <= 72; k++) begin
        @(posedge clk); @(negedge clk);
        e = model(k, levels[b], 4'hF, 32'h6DF70201);
        checks++;
        if ({frame_tick, indicator, segment} !== e) begin
          errors++;
          $display("FAIL brightness_%0d k=%0d got %h exp %h", levels[b], k,
                   {frame_tick, indicator, segment}, e);
        end
      end
    end
  endtask

  task automatic test_mask();
    logic [12:0] e;
    brightness = 4'd15; digit_mask = 4'b1011;
    restart();
    for (int k = 1; k <= 144; k++) begin
      @(posedge clk); @(negedge clk);
      e = model(k, 4'd15, 4'b1011, 32'h6DF70201);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL mask k=%0d got %h exp %h", k, {frame_tick, indicator, segment}, e);
      end
    end
    digit_mask = 4'hF;
  endtask

  // Digit 0 rewritten and brightness dropped mid-ON of digit 0; digit 1
  // rewritten on the very edge that latches digit 1's slot.
  task automatic test_mid_slot_update();
    logic [12:0] e;
    logic [31:0] p;
    logic [3:0]  b;
    int          j;
    brightness = 4'd15;
    restart();
    for (int k = 1; k <= 144; k++) begin
      @(posedge clk); @(negedge clk);
      j = k - 1;
      p = (j < 18) ? 32'h6DF70201 : (j < 72) ? 32'h6DF70240 : 32'h6DF78040;
      b = (j < 18) ? 4'd15 : 4'd4;
      e = model(k, b, 4'hF, p);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL mid_slot k=%0d got %h exp %h", k, {frame_tick, indicator, segment}, e);
      end
      if (k == 8) begin
        wif.wr_en = 1'b1; wif.wr_addr = 2'd0; wif.wr_raw = 1'b1; wif.wr_data = 8'h40;
        brightness = 4'd4;
      end else if (k == 19) begin
        wif.wr_en = 1'b1; wif.wr_addr = 2'd1; wif.wr_raw = 1'b1; wif.wr_data = 8'h80;
      end else begin
        wif.wr_en = 1'b0;
      end
    end
    brightness = 4'd15;
  endtask

  task automatic test_run_drop();
    logic [12:0] e;
    restart();
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      e = model(k, 4'd15, 4'hF, 32'h6DF78040);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL run_pre k=%0d got %h exp %h", k, {frame_tick, indicator, segment}, e);
      end
    end
    run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({frame_tick, indicator, segment} !== {1'b0, 4'hF, 8'hFF}) begin
        errors++;
        $display("FAIL run_low k=%0d got %h exp %h", k, {frame_tick, indicator, segment},
                 {1'b0, 4'hF, 8'hFF});
      end
    end
    run = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(posedge clk); @(negedge clk);
      e = model(k, 4'd15, 4'hF, 32'h6DF78040);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL run_resume k=%0d got %h exp %h", k, {frame_tick, indicator, segment}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    restart();
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); @(negedge clk);
      e = model(k, 4'd15, 4'hF, 32'h6DF78040);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL rst_pre k=%0d got %h exp %h", k, {frame_tick, indicator, segment}, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({frame_tick, indicator, segment} !== {1'b0, 4'hF, 8'hFF}) begin
      errors++;
      $display("FAIL rst_async got %h exp %h", {frame_tick, indicator, segment},
               {1'b0, 4'hF, 8'hFF});
    end
    @(negedge clk);
    rst = 1'b0;
    // Digits cleared by reset: digit selected, no segments lit.
    for (int k = 1; k <= 72; k++) begin
      @(posedge clk); @(negedge clk);
      e = model(k, 4'd15, 4'hF, 32'h00000000);
      checks++;
      if ({frame_tick, indicator, segment} !== e) begin
        errors++;
        $display("FAIL rst_resume k=%0d got %h exp %h", k, {frame_tick, indicator, segment}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw_scan();
    test_hex_decode();
    test_brightness();
    test_mask();
    test_mid_slot_update();
    test_run_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit, 8-segment indicator driven from the system's indicator/segment ports. It holds four digit registers written by a host-side write port, scans the digits round-robin with an anti-ghosting blank gap, and applies 4-bit PWM brightness. It sits between the CPU-facing register interface and the board pins, replacing direct software drive of indicator and segment lines.

Parameters:
BLANK_CYCLES, 64, clocks per slot with all digits and segments inactive (ghost suppression), ≥1
STEP_CYCLES, 256, clocks per PWM step; ON phase = 16*STEP_CYCLES clocks, ≥1
SEG_ACTIVE_LOW, 1, 1: segment outputs driven 0 when lit
DIG_ACTIVE_LOW, 1, 1: indicator outputs driven 0 when digit selected

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous, active-high reset
run  in  1  1: scanning; 0: outputs inactive, scan held at start
wr_en  in  1  one-cycle write strobe
wr_addr  in  2  digit index 0..3
wr_raw  in  1  1: wr_data is raw pattern {dp,g..a}; 0: hex decode
wr_data  in  8  pattern, or [3:0]=hex digit, [4]=dp when decoding
brightness  in  4  PWM level 0..15
digit_mask  in  4  per-digit enable; 0 keeps that digit dark in its slot
indicator  out  4  digit select (one-hot when lit)
segment  out  8  segment lines {dp,g,f,e,d,c,b,a}
frame_tick  out  1  one-cycle pulse at end of digit-3 slot

Behaviour:
- Reset (async, reset_reset=1): digit regs = 0x00 (off), digit index = 0, state = BLANK, counters = 0, indicator/segment at inactive level (all 1 with default params), frame_tick = 0. Outputs registered; inactive takes effect immediately on reset assertion.
- Writes: on wr_en, digit[wr_addr] updated next cycle. wr_raw=0: standard hex decode of wr_data[3:0] (0→0x3F, 1→0x06, … 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71), bit7 = wr_data[4]. Stored value is always raw, active-high internally.
- FSM per slot: BLANK (BLANK_CYCLES clocks) → ON (16*STEP_CYCLES clocks) → BLANK of next digit. Index increments mod 4 at ON→BLANK; 3 wraps to 0.
- At BLANK→ON transition, latch seg_lat = digit[idx], bri_lat = brightness, msk_lat = digit_mask[idx]. Writes/brightness changes mid-slot take effect at next slot start; never mid-slot.
- ON phase: step counter 0..15 (advances every STEP_CYCLES). Lit when step < bri_lat and msk_lat=1. Lit: indicator bit idx active, others inactive; segment = seg_lat (inverted if SEG_ACTIVE_LOW). Not lit, or BLANK: all indicator and segment inactive.
- brightness 0 → never lit; 15 → lit 15/16 of ON phase.
- Output registered: pins reflect state one cycle after internal condition.
- frame_tick = 1 for the single cycle in which idx 3 leaves ON.
- run=0: synchronously return to BLANK, idx 0, counters 0, outputs inactive, frame_tick 0; digit regs and writes unaffected. run 0→1 starts a full BLANK of digit 0.
- Write to the digit currently in ON: displayed pattern unchanged until that digit's next slot.
- Simultaneous wr_en and slot latch for the same digit: latch takes old value (register update visible next cycle).

Test Plan:
- BLANK_CYCLES=2, STEP_CYCLES=1, brightness=15, mask=0xF, write raw 0x01,0x02,0x04,0x08 to digits 0..3 → per slot 2 cycles indicator=0xF, then 15 cycles indicator=0xE/0xD/0xB/0x7 with segment=~pattern, 1 dark; slot period 18; frame_tick every 72 cycles.
- wr_raw=0, wr_data=0x1A to digit 2 → digit 2 segment = ~0xF7 = 0x08 when lit.
- brightness=4 → lit exactly 4 of 16 ON cycles per slot; brightness=0 → indicator stays 0xF for the entire frame.
- digit_mask=0b1011 → digit 2 slot fully dark, slot timing and frame_tick period unchanged (72 cycles).
- Write digit 0 and change brightness mid-ON of digit 0 → current slot unchanged; new values appear in digit 0's next slot.
- Assert reset_reset mid-ON, and separately drop run mid-frame → outputs inactive immediately/next cycle; on release scan restarts at digit 0 BLANK; digit contents lost only on reset.
